mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: round-robin with bounded lock bursts, one
// access in flight, registered downstream and completion outputs.
module mem_arbiter #(
  parameter int unsigned LOCK_MAX = 4,
  parameter int unsigned ADDR_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_byte,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [15:0]       m0_wdata,
  output logic [15:0]       m0_rdata,
  output logic              m0_ack,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_byte,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [15:0]       m1_wdata,
  output logic [15:0]       m1_rdata,
  output logic              m1_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic              mem_byte_en,
  output logic              mem_byte_sel,
  output logic [15:0]       mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_wait,
  output logic              owner,
  output logic              busy
);

  localparam int unsigned CNT_W = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACCESS = 1'b1;

  logic [0:0]       r_state, w_state;
  logic             r_rr, w_rr;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic             r_lock, w_lock;
  logic             r_owner, w_owner;
  logic             r_mem_en, w_mem_en;
  logic             r_mem_we, w_mem_we;
  logic             r_mem_byte_en, w_mem_byte_en;
  logic             r_mem_byte_sel, w_mem_byte_sel;
  logic [15:0]      r_mem_addr, w_mem_addr;
  logic [15:0]      r_mem_wdata, w_mem_wdata;
  logic [15:0]      r_m0_rdata, w_m0_rdata;
  logic [15:0]      r_m1_rdata, w_m1_rdata;
  logic             r_m0_ack, w_m0_ack;
  logic             r_m1_ack, w_m1_ack;
  logic             w_gnt;
  logic [ADDR_W-1:0] w_addr;

  // Grant m1 only if it asks and m0 is idle or the pointer favours m1.
  assign w_gnt  = m1_req & (~m0_req | r_rr);
  assign w_addr = w_gnt ? m1_addr : m0_addr;

  // Next-state and next-output logic; downstream fields are loaded at grant.
  always_comb begin
    w_state        = r_state;
    w_rr           = r_rr;
    w_cnt          = r_cnt;
    w_lock         = r_lock;
    w_owner        = r_owner;
    w_mem_en       = r_mem_en;
    w_mem_we       = r_mem_we;
    w_mem_byte_en  = r_mem_byte_en;
    w_mem_byte_sel = r_mem_byte_sel;
    w_mem_addr     = r_mem_addr;
    w_mem_wdata    = r_mem_wdata;
    w_m0_rdata     = r_m0_rdata;
    w_m1_rdata     = r_m1_rdata;
    w_m0_ack       = 1'b0;
    w_m1_ack       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (m0_req | m1_req) begin
          w_state        = S_ACCESS;
          w_owner        = w_gnt;
          w_lock         = w_gnt ? m1_lock : m0_lock;
          w_mem_en       = 1'b1;
          w_mem_we       = w_gnt ? m1_we : m0_we;
          w_mem_byte_en  = w_gnt ? m1_byte : m0_byte;
          w_mem_byte_sel = w_addr[0];
          w_mem_addr     = 16'(w_addr >> 1);
          w_mem_wdata    = w_gnt ? m1_wdata : m0_wdata;
        end
      end
      S_ACCESS: begin
        if (!mem_wait) begin
          w_state       = S_IDLE;
          w_mem_en      = 1'b0;
          w_mem_we      = 1'b0;
          w_mem_byte_en = 1'b0;
          if (r_owner) begin
            w_m1_rdata = mem_rdata;
            w_m1_ack   = 1'b1;
          end else begin
            w_m0_rdata = mem_rdata;
            w_m0_ack   = 1'b1;
          end
          // Locked bursts keep the pointer until the streak limit forces rotation.
          if (r_lock && (r_cnt < CNT_W'(LOCK_MAX - 1))) begin
            w_rr  = r_owner;
            w_cnt = r_cnt + CNT_W'(1);
          end else begin
            w_rr  = ~r_owner;
            w_cnt = '0;
          end
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_rr           <= 1'b0;
      r_cnt          <= '0;
      r_lock         <= 1'b0;
      r_owner        <= 1'b0;
      r_mem_en       <= 1'b0;
      r_mem_we       <= 1'b0;
      r_mem_byte_en  <= 1'b0;
      r_mem_byte_sel <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
      r_m0_rdata     <= '0;
      r_m1_rdata     <= '0;
      r_m0_ack       <= 1'b0;
      r_m1_ack       <= 1'b0;
    end else begin
      r_state        <= w_state;
      r_rr           <= w_rr;
      r_cnt          <= w_cnt;
      r_lock         <= w_lock;
      r_owner        <= w_owner;
      r_mem_en       <= w_mem_en;
      r_mem_we       <= w_mem_we;
      r_mem_byte_en  <= w_mem_byte_en;
      r_mem_byte_sel <= w_mem_byte_sel;
      r_mem_addr     <= w_mem_addr;
      r_mem_wdata    <= w_mem_wdata;
      r_m0_rdata     <= w_m0_rdata;
      r_m1_rdata     <= w_m1_rdata;
      r_m0_ack       <= w_m0_ack;
      r_m1_ack       <= w_m1_ack;
    end
  end

  assign m0_rdata     = r_m0_rdata;
  assign m1_rdata     = r_m1_rdata;
  assign m0_ack       = r_m0_ack;
  assign m1_ack       = r_m1_ack;
  assign mem_en       = r_mem_en;
  assign mem_we       = r_mem_we;
  assign mem_byte_en  = r_mem_byte_en;
  assign mem_byte_sel = r_mem_byte_sel;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign owner        = r_owner;
  assign busy         = r_mem_en;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic against a
// transaction-level model of the arbitration rules.
module tb_mem_arbiter;

  localparam int unsigned LOCK_MAX = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_we, m0_byte, m0_lock;
  logic [15:0] m0_addr, m0_wdata, m0_rdata;
  logic        m0_ack;
  logic        m1_req, m1_we, m1_byte, m1_lock;
  logic [15:0] m1_addr, m1_wdata, m1_rdata;
  logic        m1_ack;
  logic        mem_en, mem_we, mem_byte_en, mem_byte_sel;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_wait, owner, busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  mem_arbiter #(.LOCK_MAX(LOCK_MAX), .ADDR_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_byte(m0_byte), .m0_lock(m0_lock),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_ack(m0_ack),
    .m1_req(m1_req), .m1_we(m1_we), .m1_byte(m1_byte), .m1_lock(m1_lock),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_ack(m1_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_byte_en(mem_byte_en),
    .mem_byte_sel(mem_byte_sel), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_wait(mem_wait), .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;

  // Transaction-level reference: one outstanding access record plus fairness state.
  typedef struct packed {
    logic        own;
    logic        we;
    logic        byt;
    logic        lock;
    logic [15:0] addr;
    logic [15:0] wdata;
  } txn_t;

  txn_t        cur;
  bit          m_active;
  bit          m_pref;
  int          m_streak;
  logic        e_ack [2];
  logic [15:0] e_rdata [2];
  int          q_grant[$];
  int          q_cyc[$];

  task automatic model_reset();
    cur = '0; m_active = 0; m_pref = 0; m_streak = 0;
    e_ack[0] = 0; e_ack[1] = 0; e_rdata[0] = 0; e_rdata[1] = 0;
  endtask

  task automatic model_step();
    bit pick;
    e_ack[0] = 0; e_ack[1] = 0;
    if (!m_active) begin
      if (m0_req || m1_req) begin
        if (m0_req && m1_req) pick = m_pref;
        else                  pick = m1_req;
        if (pick) cur = '{1'b1, m1_we, m1_byte, m1_lock, m1_addr, m1_wdata};
        else      cur = '{1'b0, m0_we, m0_byte, m0_lock, m0_addr, m0_wdata};
        m_active = 1;
      end
    end else if (!mem_wait) begin
      e_rdata[cur.own] = mem_rdata;
      e_ack[cur.own]   = 1;
      m_active         = 0;
      if (cur.lock && (m_streak + 1 < LOCK_MAX)) begin
        m_pref = cur.own; m_streak++;
      end else begin
        m_pref = !cur.own; m_streak = 0;
      end
    end
  endtask

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    cmp("busy",         32'(busy),         32'(m_active));
    cmp("owner",        32'(owner),        32'(cur.own));
    cmp("mem_en",       32'(mem_en),       32'(m_active));
    cmp("mem_we",       32'(mem_we),       32'(m_active & cur.we));
    cmp("mem_byte_en",  32'(mem_byte_en),  32'(m_active & cur.byt));
    cmp("mem_byte_sel", 32'(mem_byte_sel), 32'(cur.addr[0]));
    cmp("mem_addr",     32'(mem_addr),     32'(cur.addr / 2));
    cmp("mem_wdata",    32'(mem_wdata),    32'(cur.wdata));
    cmp("m0_ack",       32'(m0_ack),       32'(e_ack[0]));
    cmp("m1_ack",       32'(m1_ack),       32'(e_ack[1]));
    cmp("m0_rdata",     32'(m0_rdata),     32'(e_rdata[0]));
    cmp("m1_rdata",     32'(m1_rdata),     32'(e_rdata[1]));
    if (m0_ack) begin q_grant.push_back(0); q_cyc.push_back(cyc); end
    if (m1_ack) begin q_grant.push_back(1); q_cyc.push_back(cyc); end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    compare_all();
  endtask

  task automatic idle_inputs();
    m0_req = 0; m0_we = 0; m0_byte = 0; m0_lock = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_byte = 0; m1_lock = 0; m1_addr = 0; m1_wdata = 0;
    mem_rdata = 0; mem_wait = 0;
  endtask

  // Called just after a rising edge; releases reset well before the next one.
  task automatic pulse_reset();
    rst_n = 0;
    #3;
    model_reset();
    rst_n = 1;
    q_grant.delete();
    q_cyc.delete();
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    model_reset();
    #12;
    rst_n = 1;
    compare_all();

    // Single read by m0: address split and two-cycle latency.
    m0_req = 1; m0_addr = 16'h0012; mem_rdata = 16'hBEEF;
    tick();
    cmp("r028_en",   32'(mem_en), 1);
    cmp("r028_addr", 32'(mem_addr), 32'h0009);
    cmp("r028_sel",  32'(mem_byte_sel), 0);
    m0_req = 0;
    tick();
    cmp("r028_ack",   32'(m0_ack), 1);
    cmp("r028_rdata", 32'(m0_rdata), 32'hBEEF);
    tick();

    // Both requesting without lock: strict alternation every two cycles.
    pulse_reset();
    m0_req = 1; m1_req = 1; mem_rdata = 16'h1234;
    for (int i = 0; i < 9; i++) tick();
    cmp("r029_nacks", 32'(q_grant.size()), 4);
    for (int i = 0; i < q_grant.size() && i < 4; i++) begin
      cmp("r029_order", 32'(q_grant[i]), 32'(i % 2));
      if (i > 0) cmp("r029_spacing", 32'(q_cyc[i] - q_cyc[i-1]), 2);
    end
    idle_inputs();
    tick();

    // m1 byte write stalled for three cycles.
    pulse_reset();
    m1_req = 1; m1_we = 1; m1_byte = 1; m1_addr = 16'h0103; m1_wdata = 16'h00A5;
    mem_wait = 1;
    tick();
    m1_req = 0;
    for (int i = 0; i < 4; i++) begin
      cmp("r030_addr", 32'(mem_addr), 32'h0081);
      cmp("r030_ctl", {29'd0, mem_we, mem_byte_en, mem_byte_sel}, 32'h7);
      cmp("r030_noack", 32'(m1_ack), 0);
      if (i == 3) mem_wait = 0;
      tick();
    end
    cmp("r030_ack", 32'(m1_ack), 1);
    tick();

    // Locked m0 burst is capped before m1 gets its turn.
    pulse_reset();
    m0_req = 1; m0_lock = 1; m1_req = 1;
    for (int i = 0; i < 12; i++) tick();
    cmp("r031_nacks", 32'(q_grant.size()), 6);
    for (int i = 0; i < q_grant.size() && i < 5; i++)
      cmp("r031_order", 32'(q_grant[i]), (i == 4) ? 1 : 0);
    idle_inputs();
    tick();

    // Asynchronous reset abandons a stalled access.
    pulse_reset();
    m1_req = 1; m1_addr = 16'hABCD; m1_wdata = 16'h5A5A; mem_wait = 1;
    tick();
    tick();
    rst_n = 0;
    #1;
    cmp("r032_en",   32'(mem_en), 0);
    cmp("r032_busy", 32'(busy), 0);
    cmp("r032_addr", 32'(mem_addr), 0);
    cmp("r032_wd",   32'(mem_wdata), 0);
    cmp("r032_ack",  32'(m1_ack), 0);
    #2;
    model_reset();
    rst_n = 1;
    idle_inputs();
    m0_req = 1; m1_req = 1;
    tick();
    cmp("r032_owner", 32'(owner), 0);
    cmp("r032_busy2", 32'(busy), 1);
    m0_req = 0; m1_req = 0;
    tick();
    cmp("r032_ack0", 32'(m0_ack), 1);
    tick();

    // Random traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      m0_req   = ($urandom_range(0, 99) < 55);
      m1_req   = ($urandom_range(0, 99) < 55);
      m0_we    = 1'($urandom);  m1_we    = 1'($urandom);
      m0_byte  = 1'($urandom);  m1_byte  = 1'($urandom);
      m0_lock  = ($urandom_range(0, 99) < 40);
      m1_lock  = ($urandom_range(0, 99) < 40);
      m0_addr  = 16'($urandom); m1_addr  = 16'($urandom);
      m0_wdata = 16'($urandom); m1_wdata = 16'($urandom);
      mem_rdata = 16'($urandom);
      mem_wait = ($urandom_range(0, 99) < 30);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
